// File: rtl/rggen_avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM register agent between HOSTS hosts.
// One transaction in flight; the response strobe is steered back to the issuing host.
`timescale 1ns/1ps
module rggen_avalon_arbiter #(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [HOSTS-1:0]               i_host_read,
    input  logic [HOSTS-1:0]               i_host_write,
    input  logic [ADDRESS_WIDTH*HOSTS-1:0] i_host_address,
    input  logic [BUS_WIDTH/8*HOSTS-1:0]   i_host_byteenable,
    input  logic [BUS_WIDTH*HOSTS-1:0]     i_host_writedata,
    output logic [HOSTS-1:0]               o_host_waitrequest,
    output logic [HOSTS-1:0]               o_host_readdatavalid,
    output logic [HOSTS-1:0]               o_host_writeresponsevalid,
    output logic [1:0]                     o_host_response,
    output logic [BUS_WIDTH-1:0]           o_host_readdata,
    output logic                           o_read,
    output logic                           o_write,
    output logic [ADDRESS_WIDTH-1:0]       o_address,
    output logic [BUS_WIDTH/8-1:0]         o_byteenable,
    output logic [BUS_WIDTH-1:0]           o_writedata,
    input  logic                           i_waitrequest,
    input  logic                           i_readdatavalid,
    input  logic                           i_writeresponsevalid,
    input  logic [1:0]                     i_response,
    input  logic [BUS_WIDTH-1:0]           i_readdata,
    output logic                           o_busy
);
    localparam int GW  = (HOSTS > 2) ? $clog2(HOSTS) : 1;
    localparam int BEW = BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic             busy_q, busy_d;
    logic [HOSTS-1:0] req_s;
    logic             cmd_read_s, cmd_write_s, accept_s, resp_s, resp_window_s;
    int               sel_s;

    // First requester after 'last', wrapping HOSTS-1 -> 0; 'last' itself has lowest priority.
    function automatic logic [GW-1:0] rr_pick(input logic [HOSTS-1:0] req,
                                              input logic [GW-1:0]    last);
        int            idx;
        logic [GW-1:0] pick;
        pick = last;
        for (int k = HOSTS; k >= 1; k--) begin
            idx  = int'(last) + k;
            idx  = (idx >= HOSTS) ? (idx - HOSTS) : idx;
            pick = req[GW'(idx)] ? GW'(idx) : pick;
        end
        return pick;
    endfunction

    // Granted-host command view and handshake qualifiers.
    always_comb begin
        req_s         = i_host_read | i_host_write;
        sel_s         = int'(grant_q);
        cmd_read_s    = (state_q == ST_CMD) & i_host_read[grant_q];
        cmd_write_s   = (state_q == ST_CMD) & i_host_write[grant_q] & ~i_host_read[grant_q];
        accept_s      = (cmd_read_s | cmd_write_s) & ~i_waitrequest;
        resp_s        = i_readdatavalid | i_writeresponsevalid;
        resp_window_s = (state_q == ST_RESP) | accept_s;
    end

    // Downstream command mux and per-host handshake/response steering.
    always_comb begin
        o_read                    = cmd_read_s;
        o_write                   = cmd_write_s;
        o_address                 = i_host_address[sel_s*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        o_byteenable              = i_host_byteenable[sel_s*BEW +: BEW];
        o_writedata               = i_host_writedata[sel_s*BUS_WIDTH +: BUS_WIDTH];
        o_host_response           = i_response;
        o_host_readdata           = i_readdata;
        o_host_waitrequest        = {HOSTS{1'b1}};
        o_host_readdatavalid      = {HOSTS{1'b0}};
        o_host_writeresponsevalid = {HOSTS{1'b0}};
        if (accept_s) begin
            o_host_waitrequest[grant_q] = 1'b0;
        end else begin
            o_host_waitrequest[grant_q] = 1'b1;
        end
        // Strobes outside CMD-accept/RESP (e.g. stray ones in IDLE) are dropped here.
        if (resp_window_s) begin
            o_host_readdatavalid[grant_q]      = i_readdatavalid;
            o_host_writeresponsevalid[grant_q] = i_writeresponsevalid;
        end else begin
            o_host_readdatavalid[grant_q]      = 1'b0;
            o_host_writeresponsevalid[grant_q] = 1'b0;
        end
    end

    // Next-state logic for the IDLE -> CMD -> RESP sequence.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_s) begin
                    state_d = ST_CMD;
                    grant_d = rr_pick(req_s, last_q);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                // A host withdrawing its command aborts without touching fairness history.
                if (!(i_host_read[grant_q] | i_host_write[grant_q])) begin
                    state_d = ST_IDLE;
                end else if (accept_s) begin
                    last_d  = grant_q;
                    state_d = resp_s ? ST_IDLE : ST_RESP;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_RESP: begin
                state_d = resp_s ? ST_IDLE : ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, grant and round-robin history registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= {GW{1'b0}};
            last_q  <= GW'(HOSTS - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: tb/tb_rggen_avalon_arbiter.sv
// Bench for rggen_avalon_arbiter (HOSTS=3): a transaction-level ownership model checked
// every cycle, a small reactive register agent, and directed scenarios with literal pins.
`timescale 1ns/1ps
module tb_rggen_avalon_arbiter;
    localparam int H  = 3;
    localparam int AW = 8;
    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [H-1:0]      host_read, host_write;
    logic [H*AW-1:0]   host_address;
    logic [H*BW/8-1:0] host_byteenable;
    logic [H*BW-1:0]   host_writedata;
    logic [H-1:0]      o_host_waitrequest, o_host_readdatavalid, o_host_writeresponsevalid;
    logic [1:0]        o_host_response;
    logic [BW-1:0]     o_host_readdata;
    logic              o_read, o_write, o_busy;
    logic [AW-1:0]     o_address;
    logic [BW/8-1:0]   o_byteenable;
    logic [BW-1:0]     o_writedata;
    logic              i_waitrequest, i_readdatavalid, i_writeresponsevalid;
    logic [1:0]        i_response;
    logic [BW-1:0]     i_readdata;

    rggen_avalon_arbiter #(.HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_host_read(host_read), .i_host_write(host_write),
        .i_host_address(host_address), .i_host_byteenable(host_byteenable),
        .i_host_writedata(host_writedata),
        .o_host_waitrequest(o_host_waitrequest), .o_host_readdatavalid(o_host_readdatavalid),
        .o_host_writeresponsevalid(o_host_writeresponsevalid),
        .o_host_response(o_host_response), .o_host_readdata(o_host_readdata),
        .o_read(o_read), .o_write(o_write), .o_address(o_address),
        .o_byteenable(o_byteenable), .o_writedata(o_writedata),
        .i_waitrequest(i_waitrequest), .i_readdatavalid(i_readdatavalid),
        .i_writeresponsevalid(i_writeresponsevalid), .i_response(i_response),
        .i_readdata(i_readdata), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: m_owner = host holding the agent (-1 none), m_acc = command taken.
    int   m_owner = -1;
    logic m_acc   = 1'b0;
    int   m_last  = H - 1;

    function automatic int m_next();
        int pick = -1;
        for (int k = 1; k <= H; k++) begin
            int h = (m_last + k) % H;
            if (pick < 0 && (host_read[h] || host_write[h])) pick = h;
        end
        return pick;
    endfunction

    function automatic logic m_accept();
        if (m_owner < 0 || m_acc) return 1'b0;
        return (host_read[m_owner] || host_write[m_owner]) && !i_waitrequest;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= -1;
            m_acc   <= 1'b0;
            m_last  <= H - 1;
        end else if (m_owner < 0) begin
            if (m_next() >= 0) begin
                m_owner <= m_next();
                m_acc   <= 1'b0;
            end
        end else if (!m_acc) begin
            if (!(host_read[m_owner] || host_write[m_owner])) begin
                m_owner <= -1;
            end else if (m_accept()) begin
                m_last <= m_owner;
                if (i_readdatavalid || i_writeresponsevalid) m_owner <= -1;
                else m_acc <= 1'b1;
            end
        end else if (i_readdatavalid || i_writeresponsevalid) begin
            m_owner <= -1;
            m_acc   <= 1'b0;
        end
    end

    // Register agent: waits ag_wait cycles, answers ag_lat cycles after accept (0 = same cycle).
    int        ag_wait, ag_lat, ag_pend, ag_wcnt;
    logic      ag_pend_rd, stray;
    logic [1:0]    ag_resp;
    logic [BW-1:0] ag_data;

    task automatic ag_fire(input logic rd);
        i_readdatavalid      = rd;
        i_writeresponsevalid = !rd;
        i_response           = ag_resp;
        i_readdata           = ag_data;
    endtask

    initial begin
        ag_pend = 0; ag_wcnt = 0; ag_pend_rd = 1'b0;
        i_waitrequest = 1'b1; i_readdatavalid = 1'b0; i_writeresponsevalid = 1'b0;
        i_response = 2'b00; i_readdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            i_readdatavalid = 1'b0; i_writeresponsevalid = 1'b0;
            i_waitrequest = 1'b1; i_response = 2'b00;
            if (ag_pend > 0) begin
                ag_pend--;
                if (ag_pend == 0) ag_fire(ag_pend_rd);
            end
            if (stray) i_readdatavalid = 1'b1;
            if (o_read || o_write) begin
                if (ag_wcnt < ag_wait) begin
                    ag_wcnt++;
                end else begin
                    i_waitrequest = 1'b0;
                    ag_wcnt = 0;
                    ag_pend_rd = o_read;
                    if (ag_lat == 0) ag_fire(o_read);
                    else ag_pend = ag_lat;
                end
            end else begin
                ag_wcnt = 0;
            end
        end
    end

    // Host stimulus: each host issues h_cnt commands, holding until its waitrequest drops.
    int            h_cnt [H];
    logic          h_rd  [H];
    logic [AW-1:0] h_addr[H];
    logic [BW-1:0] h_wd  [H];

    int   rdv_cnt[H], wrv_cnt[H], wlow_cnt[H];
    int   s_rdv[H], s_wrv[H], s_wlow[H];
    int   busy_cycles = 0, wr_run = 0, wlow_run = 0, base = 0, s_busy = 0;
    int   glog[$];
    logic [BW-1:0] last_data = 32'h0;
    logic [1:0]    last_resp = 2'b00;

    task automatic drive_hosts();
        for (int h = 0; h < H; h++) begin
            host_read[h]  = (h_cnt[h] > 0) && h_rd[h];
            host_write[h] = (h_cnt[h] > 0) && !h_rd[h];
            host_address[h*AW +: AW]     = h_addr[h];
            host_byteenable[h*4 +: 4]    = 4'hF;
            host_writedata[h*BW +: BW]   = h_wd[h];
        end
    endtask

    // Every-cycle comparison against the ownership model plus event bookkeeping.
    task automatic sample();
        logic [H-1:0] ew, erdv, ewrv;
        logic erd, ewr, eacc;
        int o;
        o = m_owner; ew = 3'b111; erdv = 3'b000; ewrv = 3'b000;
        erd = 1'b0; ewr = 1'b0; eacc = 1'b0;
        if (o >= 0 && !m_acc) begin
            erd  = host_read[o];
            ewr  = host_write[o] && !host_read[o];
            eacc = (erd || ewr) && !i_waitrequest;
            if (eacc) ew[o] = 1'b0;
        end
        if (o >= 0 && (m_acc || eacc)) begin
            erdv[o] = i_readdatavalid;
            ewrv[o] = i_writeresponsevalid;
        end
        check("busy", o_busy, o >= 0);
        check("read", o_read, erd);
        check("write", o_write, ewr);
        check("waitrequest", o_host_waitrequest, ew);
        check("readdatavalid", o_host_readdatavalid, erdv);
        check("writeresponsevalid", o_host_writeresponsevalid, ewrv);
        check("response", o_host_response, i_response);
        check("readdata", o_host_readdata, i_readdata);
        if (erd || ewr) begin
            check("address", o_address, host_address[o*AW +: AW]);
            check("byteenable", o_byteenable, host_byteenable[o*4 +: 4]);
            check("writedata", o_writedata, host_writedata[o*BW +: BW]);
        end
        wr_run = o_write ? wr_run + 1 : 0;
        if (o_busy) busy_cycles++;
        for (int h = 0; h < H; h++) begin
            if (!o_host_waitrequest[h]) begin wlow_cnt[h]++; wlow_run = wr_run; end
            if (o_host_readdatavalid[h] || o_host_writeresponsevalid[h]) begin
                glog.push_back(h);
                last_data = o_host_readdata;
                last_resp = o_host_response;
            end
            if (o_host_readdatavalid[h]) rdv_cnt[h]++;
            if (o_host_writeresponsevalid[h]) wrv_cnt[h]++;
        end
    endtask

    task automatic run_cycles(input int n);
        logic [H-1:0] acc;
        for (int c = 0; c < n; c++) begin
            drive_hosts();
            @(negedge clk);
            acc = ~o_host_waitrequest;
            sample();
            @(posedge clk); #1;
            for (int h = 0; h < H; h++) if (acc[h] && h_cnt[h] > 0) h_cnt[h]--;
        end
        drive_hosts();
    endtask

    task automatic snap();
        s_rdv = rdv_cnt; s_wrv = wrv_cnt; s_wlow = wlow_cnt;
        base = glog.size(); s_busy = busy_cycles;
    endtask

    initial begin
        rst_n = 1'b0; stray = 1'b0;
        ag_wait = 0; ag_lat = 1; ag_resp = 2'b00; ag_data = 32'h0;
        for (int h = 0; h < H; h++) begin
            h_cnt[h] = 0; h_rd[h] = 1'b0; h_addr[h] = 8'h00; h_wd[h] = 32'h0;
            rdv_cnt[h] = 0; wrv_cnt[h] = 0; wlow_cnt[h] = 0;
        end
        drive_hosts();
        @(posedge clk); @(posedge clk); #2;
        check("rst_waitrequest", o_host_waitrequest, 3'b111);
        check("rst_busy", o_busy, 1'b0);
        check("rst_cmd", {o_read, o_write}, 2'b00);
        check("rst_valids", {o_host_readdatavalid, o_host_writeresponsevalid}, 6'b0);
        @(posedge clk); #1; rst_n = 1'b1;

        // All three hosts write twice each: grants rotate 0,1,2,0,1,2.
        for (int h = 0; h < H; h++) begin
            h_cnt[h] = 2; h_rd[h] = 1'b0;
            h_addr[h] = 8'(8'h20 + 4 * h); h_wd[h] = 32'hA000_0000 + 32'(h);
        end
        snap();
        run_cycles(22);
        check("rr_count", glog.size() - base, 6);
        check("rr_order0", glog[base], 0);
        check("rr_order1", glog[base+1], 1);
        check("rr_order2", glog[base+2], 2);
        check("rr_order3", glog[base+3], 0);
        for (int h = 0; h < H; h++) begin
            check("rr_wait_drops", wlow_cnt[h] - s_wlow[h], 2);
            check("rr_wrv", wrv_cnt[h] - s_wrv[h], 2);
        end

        // Single read by host 1.
        ag_data = 32'hCAFE_0001;
        h_cnt[1] = 1; h_rd[1] = 1'b1; h_addr[1] = 8'h10;
        snap();
        run_cycles(6);
        check("rd_valid_h1", rdv_cnt[1] - s_rdv[1], 1);
        check("rd_valid_others", (rdv_cnt[0] - s_rdv[0]) + (rdv_cnt[2] - s_rdv[2]), 0);
        check("rd_data", last_data, 32'hCAFE_0001);
        check("rd_resp", last_resp, 2'b00);
        check("rd_h0_wait", wlow_cnt[0] - s_wlow[0], 0);

        // Host 2 withdraws before accept, then is re-granted ahead of host 0.
        ag_wait = 20;
        h_cnt[2] = 1; h_rd[2] = 1'b1; h_addr[2] = 8'h30;
        snap();
        run_cycles(3);
        h_cnt[2] = 0;
        run_cycles(2);
        check("abort_no_accept", wlow_cnt[2] - s_wlow[2], 0);
        check("abort_no_resp", glog.size() - base, 0);
        check("abort_idle", o_busy, 1'b0);
        ag_wait = 0;
        h_cnt[2] = 1; h_rd[2] = 1'b0; h_cnt[0] = 1; h_rd[0] = 1'b0;
        snap();
        run_cycles(10);
        check("regrant_count", glog.size() - base, 2);
        check("regrant_first", glog[base], 2);
        check("regrant_second", glog[base+1], 0);

        // Backpressure: four wait cycles, command held five cycles.
        ag_wait = 4;
        h_cnt[1] = 1; h_rd[1] = 1'b0; h_addr[1] = 8'h44; h_wd[1] = 32'h1234_5678;
        snap();
        run_cycles(10);
        check("bp_accept_cycle", wlow_run, 5);
        check("bp_wait_drops", wlow_cnt[1] - s_wlow[1], 1);
        check("bp_wrv", wrv_cnt[1] - s_wrv[1], 1);

        // Error response on host 0 write, then arbitration resumes at host 1.
        ag_wait = 0; ag_resp = 2'b10;
        h_cnt[0] = 1; h_rd[0] = 1'b0; h_wd[0] = 32'hDEAD_BEEF;
        snap();
        run_cycles(6);
        check("err_wrv_h0", wrv_cnt[0] - s_wrv[0], 1);
        check("err_resp", last_resp, 2'b10);
        ag_resp = 2'b00;
        for (int h = 0; h < H; h++) begin h_cnt[h] = 1; h_rd[h] = 1'b0; end
        snap();
        run_cycles(12);
        check("err_next_count", glog.size() - base, 3);
        check("err_next_first", glog[base], 1);
        check("err_next_last", glog[base+2], 0);

        // Stray read strobe while idle.
        snap();
        stray = 1'b1;
        run_cycles(1);
        stray = 1'b0;
        run_cycles(2);
        check("stray_ignored", glog.size() - base, 0);

        // Zero-latency agent: response in the accept cycle, one busy cycle.
        ag_lat = 0; ag_data = 32'h5A5A_0002;
        h_cnt[2] = 1; h_rd[2] = 1'b1;
        snap();
        run_cycles(6);
        check("zl_rdv_h2", rdv_cnt[2] - s_rdv[2], 1);
        check("zl_busy_cycles", busy_cycles - s_busy, 1);
        check("zl_data", last_data, 32'h5A5A_0002);

        // Reset while waiting in RESP; the late response must be discarded.
        ag_lat = 2; ag_data = 32'h0000_0BAD;
        h_cnt[0] = 1; h_rd[0] = 1'b1; h_addr[0] = 8'h08;
        run_cycles(2);
        check("pre_reset_busy", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_waitrequest", o_host_waitrequest, 3'b111);
        check("mid_rst_cmd", {o_read, o_write}, 2'b00);
        @(negedge clk);
        sample();
        @(posedge clk); #1; rst_n = 1'b1;
        snap();
        run_cycles(3);
        check("post_rst_discard", glog.size() - base, 0);
        check("post_rst_busy", o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
